// File: rtl/sauria_cfg_bridge.sv
// Converts single-beat regbus requests from the Cheshire external slave port into
// AXI4-Lite transactions on the SAURIA config port, one transaction at a time.
//
// state  | meaning
// IDLE   | waiting for reg_valid_i; decodes the address and latches the request
// WR_REQ | AW and W offered together, each withdrawn after its own handshake
// WR_RSP | cfg_b_ready_o high, waiting for the write response
// RD_REQ | AR offered until its handshake
// RD_RSP | cfg_r_ready_o high, waiting for read data
// DONE   | one-cycle reg_ready_o pulse carrying rdata/error
module sauria_cfg_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CFG_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reg_valid_i,
  input  logic                      reg_write_i,
  input  logic [ADDR_WIDTH-1:0]     reg_addr_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   reg_wstrb_i,
  output logic                      reg_ready_o,
  output logic [DATA_WIDTH-1:0]     reg_rdata_o,
  output logic                      reg_error_o,
  output logic                      cfg_aw_valid_o,
  input  logic                      cfg_aw_ready_i,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_aw_addr_o,
  output logic                      cfg_w_valid_o,
  input  logic                      cfg_w_ready_i,
  output logic [DATA_WIDTH-1:0]     cfg_w_data_o,
  output logic [DATA_WIDTH/8-1:0]   cfg_w_strb_o,
  input  logic                      cfg_b_valid_i,
  output logic                      cfg_b_ready_o,
  input  logic [1:0]                cfg_b_resp_i,
  output logic                      cfg_ar_valid_o,
  input  logic                      cfg_ar_ready_i,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_ar_addr_o,
  input  logic                      cfg_r_valid_i,
  output logic                      cfg_r_ready_o,
  input  logic [DATA_WIDTH-1:0]     cfg_r_data_i,
  input  logic [1:0]                cfg_r_resp_i
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CFG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      ready_q, ready_d;
  logic                      error_q, error_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      addr_err;
  logic                      aw_done, w_done;

  // Misaligned or outside the SAURIA window: answered locally, never reaches AXI.
  assign addr_err = (reg_addr_i[1:0] != 2'b00) || ((reg_addr_i >> CFG_ADDR_WIDTH) != '0);
  assign aw_done  = !aw_valid_q || cfg_aw_ready_i;
  assign w_done   = !w_valid_q || cfg_w_ready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    rdata_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          addr_d  = reg_addr_i[CFG_ADDR_WIDTH-1:0];
          wdata_d = reg_wdata_i;
          wstrb_d = reg_wstrb_i;
          if (addr_err) begin
            state_d = DONE;
            ready_d = 1'b1;
            error_d = 1'b1;
          end else if (reg_write_i) begin
            state_d    = WR_REQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RD_REQ;
            ar_valid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_valid_q && cfg_aw_ready_i) aw_valid_d = 1'b0;
        if (w_valid_q && cfg_w_ready_i)   w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d   = WR_RSP;
          b_ready_d = 1'b1;
        end
      end
      WR_RSP: begin
        if (cfg_b_valid_i) begin
          state_d   = DONE;
          b_ready_d = 1'b0;
          ready_d   = 1'b1;
          error_d   = (cfg_b_resp_i != 2'b00);
        end
      end
      RD_REQ: begin
        if (cfg_ar_ready_i) begin
          state_d    = RD_RSP;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD_RSP: begin
        if (cfg_r_valid_i) begin
          state_d   = DONE;
          r_ready_d = 1'b0;
          ready_d   = 1'b1;
          error_d   = (cfg_r_resp_i != 2'b00);
          rdata_d   = cfg_r_data_i;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      rdata_q    <= rdata_d;
    end
  end

  assign reg_ready_o    = ready_q;
  assign reg_error_o    = error_q;
  assign reg_rdata_o    = rdata_q;
  assign cfg_aw_valid_o = aw_valid_q;
  assign cfg_aw_addr_o  = addr_q;
  assign cfg_w_valid_o  = w_valid_q;
  assign cfg_w_data_o   = wdata_q;
  assign cfg_w_strb_o   = wstrb_q;
  assign cfg_b_ready_o  = b_ready_q;
  assign cfg_ar_valid_o = ar_valid_q;
  assign cfg_ar_addr_o  = addr_q;
  assign cfg_r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_sauria_cfg_bridge.sv
// Bench for sauria_cfg_bridge: regbus master driver, delay-programmable AXI4-Lite
// slave model, and a scoreboard of expected regbus responses.
module tb_sauria_cfg_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_valid_i, reg_write_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o, reg_error_o;
  logic [31:0] reg_rdata_o;
  logic        cfg_aw_valid_o, cfg_aw_ready_i;
  logic [11:0] cfg_aw_addr_o;
  logic        cfg_w_valid_o, cfg_w_ready_i;
  logic [31:0] cfg_w_data_o;
  logic [3:0]  cfg_w_strb_o;
  logic        cfg_b_valid_i, cfg_b_ready_o;
  logic [1:0]  cfg_b_resp_i;
  logic        cfg_ar_valid_o, cfg_ar_ready_i;
  logic [11:0] cfg_ar_addr_o;
  logic        cfg_r_valid_i, cfg_r_ready_o;
  logic [31:0] cfg_r_data_i;
  logic [1:0]  cfg_r_resp_i;

  sauria_cfg_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
    .cfg_aw_valid_o(cfg_aw_valid_o), .cfg_aw_ready_i(cfg_aw_ready_i), .cfg_aw_addr_o(cfg_aw_addr_o),
    .cfg_w_valid_o(cfg_w_valid_o), .cfg_w_ready_i(cfg_w_ready_i),
    .cfg_w_data_o(cfg_w_data_o), .cfg_w_strb_o(cfg_w_strb_o),
    .cfg_b_valid_i(cfg_b_valid_i), .cfg_b_ready_o(cfg_b_ready_o), .cfg_b_resp_i(cfg_b_resp_i),
    .cfg_ar_valid_o(cfg_ar_valid_o), .cfg_ar_ready_i(cfg_ar_ready_i), .cfg_ar_addr_o(cfg_ar_addr_o),
    .cfg_r_valid_i(cfg_r_valid_i), .cfg_r_ready_o(cfg_r_ready_o),
    .cfg_r_data_i(cfg_r_data_i), .cfg_r_resp_i(cfg_r_resp_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Slave model knobs, set by the stimulus before each request.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  // Slave bookkeeping.
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_done, w_done, ar_done;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, viol_n = 0;
  logic [11:0] aw_addr_seen, ar_addr_seen;
  logic [31:0] w_data_seen;
  logic [3:0]  w_strb_seen;

  // Handshakes are decided at a negedge (valid and ready both high) and take
  // effect at the following posedge; they are booked at the next negedge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      cfg_aw_ready_i = 1'b0; cfg_w_ready_i = 1'b0; cfg_ar_ready_i = 1'b0;
      cfg_b_valid_i = 1'b0; cfg_b_resp_i = 2'b00;
      cfg_r_valid_i = 1'b0; cfg_r_data_i = 32'h0; cfg_r_resp_i = 2'b00;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
      hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0; hs_ar = 1'b0; hs_r = 1'b0;
    end else begin
      if (hs_aw) begin aw_done = 1'b1; aw_hs_n++; end
      if (hs_w)  begin w_done = 1'b1;  w_hs_n++;  end
      if (hs_b)  begin cfg_b_valid_i = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_cnt = 0; b_hs_n++; end
      if (hs_ar) begin ar_done = 1'b1; ar_hs_n++; end
      if (hs_r)  begin cfg_r_valid_i = 1'b0; ar_done = 1'b0; r_cnt = 0; r_hs_n++; end

      if (cfg_aw_valid_o) begin
        aw_vcyc++;
        if (aw_done) viol_n++;
        cfg_aw_ready_i = (aw_cnt >= aw_dly);
        aw_cnt++;
      end else begin
        cfg_aw_ready_i = 1'b0;
        aw_cnt = 0;
      end
      if (cfg_w_valid_o) begin
        w_vcyc++;
        if (w_done) viol_n++;
        cfg_w_ready_i = (w_cnt >= w_dly);
        w_cnt++;
      end else begin
        cfg_w_ready_i = 1'b0;
        w_cnt = 0;
      end
      if (cfg_ar_valid_o) begin
        ar_vcyc++;
        if (ar_done) viol_n++;
        cfg_ar_ready_i = (ar_cnt >= ar_dly);
        ar_cnt++;
      end else begin
        cfg_ar_ready_i = 1'b0;
        ar_cnt = 0;
      end

      if (aw_done && w_done && !cfg_b_valid_i) begin
        if (b_cnt >= b_dly) begin cfg_b_valid_i = 1'b1; cfg_b_resp_i = b_resp; end
        else b_cnt++;
      end
      if (ar_done && !cfg_r_valid_i) begin
        if (r_cnt >= r_dly) begin
          cfg_r_valid_i = 1'b1; cfg_r_data_i = r_data; cfg_r_resp_i = r_resp;
        end else r_cnt++;
      end

      hs_aw = cfg_aw_valid_o && cfg_aw_ready_i;
      hs_w  = cfg_w_valid_o && cfg_w_ready_i;
      hs_b  = cfg_b_valid_i && cfg_b_ready_o;
      hs_ar = cfg_ar_valid_o && cfg_ar_ready_i;
      hs_r  = cfg_r_valid_i && cfg_r_ready_o;
      if (hs_aw) aw_addr_seen = cfg_aw_addr_o;
      if (hs_w) begin w_data_seen = cfg_w_data_o; w_strb_seen = cfg_w_strb_o; end
      if (hs_ar) ar_addr_seen = cfg_ar_addr_o;
    end
  end

  // Scoreboard: every reg_ready_o pulse consumes one expected response.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (reg_ready_o) begin
        if (sb_q.size() == 0) chk("sb_unexpected_ready", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", reg_rdata_o, e.rdata);
          chk("rsp_error", reg_error_o, e.err);
        end
      end else begin
        chk("idle_rsp_zero", {reg_error_o, reg_rdata_o}, 33'h0);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    logic got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(negedge clk_i);
    reg_valid_i = 1'b1; reg_write_i = wr; reg_addr_i = addr;
    reg_wdata_i = wd; reg_wstrb_i = ws;
    @(posedge clk_i);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk_i);
      if (reg_ready_o) begin got = 1'b1; lat = i; end
    end
    reg_valid_i = 1'b0;
    chk("ready_seen", got, 1'b1);
    chk("latency", lat, exp_lat);
    @(negedge clk_i);
    chk("ready_one_cycle", reg_ready_o, 1'b0);
  endtask

  int snap_aw, snap_w, snap_ar, snap_b, snap_v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_addr_i = 32'h0;
    reg_wdata_i = 32'h0; reg_wstrb_i = 4'h0;
    #1;
    chk("reset_ctrl", {reg_ready_o, reg_error_o, cfg_aw_valid_o, cfg_w_valid_o,
                       cfg_b_ready_o, cfg_ar_valid_o, cfg_r_ready_o}, 7'h0);
    chk("reset_data", {reg_rdata_o, cfg_w_data_o, cfg_w_strb_o, cfg_aw_addr_o, cfg_ar_addr_o}, 92'h0);
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_i = 1'b0;

    // Zero-wait write
    snap_b = b_hs_n;
    do_req(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
    chk("wr_aw_addr", aw_addr_seen, 12'h010);
    chk("wr_w_data", w_data_seen, 32'hDEADBEEF);
    chk("wr_w_strb", w_strb_seen, 4'hF);
    chk("wr_b_count", b_hs_n - snap_b, 1);

    // Read with R delayed 5 cycles
    r_dly = 5; r_data = 32'h0000CAFE;
    do_req(1'b0, 32'h024, 32'h0, 4'h0, 32'h0000CAFE, 1'b0, 8);
    chk("rd_ar_addr", ar_addr_seen, 12'h024);

    // W accepted 4 cycles after AW
    r_dly = 0; w_dly = 4;
    snap_aw = aw_vcyc; snap_w = w_vcyc; snap_b = b_hs_n;
    do_req(1'b1, 32'h0A8, 32'h01234567, 4'h3, 32'h0, 1'b0, 7);
    chk("split_aw_valid_cycles", aw_vcyc - snap_aw, 1);
    chk("split_w_valid_cycles", w_vcyc - snap_w, 5);
    chk("split_b_count", b_hs_n - snap_b, 1);
    chk("split_w_strb", w_strb_seen, 4'h3);
    chk("split_aw_addr", aw_addr_seen, 12'h0A8);
    w_dly = 0;

    // Read with SLVERR: data still forwarded, error flagged
    r_resp = 2'b10; r_data = 32'h12345678;
    do_req(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h12345678, 1'b1, 3);
    r_resp = 2'b00;

    // Write with DECERR and a delayed B
    b_resp = 2'b11; b_dly = 2;
    do_req(1'b1, 32'h100, 32'hA5A5A5A5, 4'h1, 32'h0, 1'b1, 5);
    b_resp = 2'b00; b_dly = 0;

    // Address errors never reach AXI
    snap_v = aw_vcyc + w_vcyc + ar_vcyc;
    do_req(1'b1, 32'h003, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    chk("addr_err_no_axi", aw_vcyc + w_vcyc + ar_vcyc - snap_v, 0);

    // Reset while waiting for B
    b_dly = 20;
    @(negedge clk_i);
    reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = 32'h040;
    reg_wdata_i = 32'h55AA55AA; reg_wstrb_i = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    reg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_b_ready", cfg_b_ready_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_ctrl", {reg_ready_o, reg_error_o, cfg_aw_valid_o, cfg_w_valid_o,
                         cfg_b_ready_o, cfg_ar_valid_o, cfg_r_ready_o}, 7'h0);
    chk("mid_rst_data", {reg_rdata_o, cfg_w_data_o, cfg_w_strb_o, cfg_aw_addr_o}, 80'h0);
    @(negedge clk_i); @(posedge clk_i); #2;
    rst_i = 1'b0;
    b_dly = 0;
    r_data = 32'h00BEEF01;
    do_req(1'b0, 32'h07C, 32'h0, 4'h0, 32'h00BEEF01, 1'b0, 3);
    chk("post_rst_ar_addr", ar_addr_seen, 12'h07C);

    chk("valid_after_handshake", viol_n, 0);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
